// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: one start bit (0), DATA_W payload bits
// LSB first, one stop bit (1); every bit is held for CLKS_PER_BIT clock cycles.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [DATA_W-1:0] din,
    input  logic              valid,
    output logic              ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic              ready_q, txd_q, busy_q, done_q;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    bit_q  <= '0;
                    // ready_q is low on the first edge out of reset, so nothing is taken then
                    if (ready_q && valid) begin
                        shreg_q <= din;
                        state_q <= START;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        txd_q   <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        txd_q   <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                            // a one-cycle stop bit is itself the last cycle
                            if (CLKS_PER_BIT == 1) done_q <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            txd_q   <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        txd_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CNT_PRE) done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign txd   = txd_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed + random frames on two instances (4 and 1 clocks per bit), compared against
// an expected line waveform built directly from the frame format.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] din0, din1;
    logic       valid0, valid1;
    logic       ready0, txd0, busy0, done0;
    logic       ready1, txd1, busy1, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .clrn(clrn), .din(din0), .valid(valid0),
        .ready(ready0), .txd(txd0), .busy(busy0), .done(done0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .clrn(clrn), .din(din1), .valid(valid1),
        .ready(ready1), .txd(txd1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin valid0 = v; din0 = d; end
        else          begin valid1 = v; din1 = d; end
    endtask

    function automatic logic o_txd(input int sel);   return sel ? txd1   : txd0;   endfunction
    function automatic logic o_busy(input int sel);  return sel ? busy1  : busy0;  endfunction
    function automatic logic o_ready(input int sel); return sel ? ready1 : ready0; endfunction
    function automatic logic o_done(input int sel);  return sel ? done1  : done0;  endfunction

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, "_txd"},   o_txd(sel),   1'b1);
        chk({tag, "_busy"},  o_busy(sel),  1'b0);
        chk({tag, "_ready"}, o_ready(sel), 1'b1);
        chk({tag, "_done"},  o_done(sel),  1'b0);
    endtask

    // Entered and left at a negedge. keep: valid stays high carrying nxt (back-to-back).
    // inject_at: frame cycle at which a one-cycle 0x3C offer is made while busy.
    // abort_at: frame cycle after which reset is asserted.
    task automatic run_frame(input int sel, input logic [7:0] data, input bit keep,
                             input logic [7:0] nxt, input int inject_at, input int abort_at);
        int cpb;
        int n;
        logic exp_line[$];
        cpb = (sel != 0) ? 1 : 4;
        n   = 10 * cpb;
        exp_line = {};
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < cpb; c++)
                exp_line.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1]);

        chk("pre_ready", o_ready(sel), 1'b1);
        drive(sel, 1'b1, data);
        @(posedge clk);
        @(negedge clk);
        // first post-acceptance value is the bitwise complement, then random
        drive(sel, keep, keep ? nxt : ~data);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("f_txd_s%0d_k%0d", sel, k),   o_txd(sel),   exp_line[k]);
            chk($sformatf("f_busy_s%0d_k%0d", sel, k),  o_busy(sel),  1'b1);
            chk($sformatf("f_ready_s%0d_k%0d", sel, k), o_ready(sel), 1'b0);
            chk($sformatf("f_done_s%0d_k%0d", sel, k),  o_done(sel),  (k == n - 1));
            if (k == abort_at) begin
                clrn = 1'b0;
                drive(sel, 1'b0, 8'h00);
                for (int r = 0; r < 3; r++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("abort_txd",   o_txd(sel),   1'b1);
                    chk("abort_busy",  o_busy(sel),  1'b0);
                    chk("abort_ready", o_ready(sel), 1'b0);
                    chk("abort_done",  o_done(sel),  1'b0);
                end
                return;
            end
            if (k == inject_at)  drive(sel, 1'b1, 8'h3C);
            else if (!keep)      drive(sel, 1'b0, 8'($urandom));
            else                 drive(sel, 1'b1, nxt);
            @(negedge clk);
        end
        chk_idle(sel, "post");
        if (!keep) drive(sel, 1'b0, 8'($urandom));
    endtask

    initial begin
        clrn = 1'b0;
        valid0 = 1'b0; din0 = 8'h00;
        valid1 = 1'b0; din1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd0",   txd0,   1'b1);
        chk("rst_busy0",  busy0,  1'b0);
        chk("rst_ready0", ready0, 1'b0);
        chk("rst_done0",  done0,  1'b0);
        chk("rst_txd1",   txd1,   1'b1);
        chk("rst_ready1", ready1, 1'b0);

        // valid offered on the first edge out of reset must not be taken
        clrn = 1'b1;
        valid0 = 1'b1; din0 = 8'hE7;
        @(posedge clk);
        @(negedge clk);
        chk("rel_ready", ready0, 1'b1);
        chk("rel_busy",  busy0,  1'b0);
        chk("rel_txd",   txd0,   1'b1);
        valid0 = 1'b0;
        @(negedge clk);
        chk_idle(0, "idle0");

        run_frame(0, 8'hA5, 1'b0, 8'h00, -1, -1);
        @(negedge clk);

        run_frame(0, 8'h00, 1'b1, 8'hFF, -1, -1);
        run_frame(0, 8'hFF, 1'b0, 8'h00, -1, -1);
        @(negedge clk);

        run_frame(0, 8'h96, 1'b0, 8'h00, 12, -1);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("noextra_busy", busy0, 1'b0);
            chk("noextra_txd",  txd0,  1'b1);
        end

        run_frame(0, 8'h55, 1'b0, 8'h00, -1, -1);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_frame(0, 8'($urandom), 1'b0, 8'h00, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        run_frame(1, 8'h81, 1'b0, 8'h00, -1, -1);
        @(negedge clk);
        run_frame(1, 8'h5A, 1'b1, 8'hC3, -1, -1);
        run_frame(1, 8'hC3, 1'b0, 8'h00, -1, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 8'($urandom), 1'b0, 8'h00, -1, -1);
            @(negedge clk);
        end

        run_frame(0, 8'($urandom), 1'b0, 8'h00, -1, 15);
        clrn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rec_ready", ready0, 1'b1);
        chk("rec_busy",  busy0,  1'b0);
        chk("rec_txd",   txd0,   1'b1);
        run_frame(0, 8'h3C, 1'b0, 8'h00, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 8, payload bits per frame (>=1).
REQ-002 Parameter CLKS_PER_BIT SHALL be: CLKS_PER_BIT, default 4, clk cycles per serial bit (>=1).
REQ-003 Port clk SHALL be: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port clrn SHALL be: clrn  input  1  reset, synchronous, active-low.
REQ-005 Port din SHALL be: din  input  DATA_W  parallel payload, sampled at acceptance only.
REQ-006 Port valid SHALL be: valid  input  1  producer offers din.
REQ-007 Port ready SHALL be: ready  output  1  registered, block can accept a word this cycle.
REQ-008 Port txd SHALL be: txd  output  1  registered serial line, idle high.
REQ-009 Port busy SHALL be: busy  output  1  registered, frame in progress.
REQ-010 Port done SHALL be: done  output  1  registered, one-cycle pulse at frame end.
REQ-011 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; ready=1 only in IDLE, busy=1 in START/DATA/STOP.
REQ-013 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; din captured into a shift register at that edge, FSM -> START.
REQ-014 valid while ready=0 SHALL be ignored; din changes after acceptance SHALL not affect the frame in flight.
REQ-015 txd SHALL drive 0 for the CLKS_PER_BIT cycles starting the cycle after acceptance (start bit).
REQ-016 DATA SHALL shift DATA_W bits LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-017 STOP SHALL drive txd=1 for CLKS_PER_BIT cycles; total frame = (DATA_W+2)*CLKS_PER_BIT cycles of busy=1.
REQ-018 done SHALL be 1 for exactly the last cycle of the stop bit; next edge FSM -> IDLE, ready=1, busy=0.
REQ-019 Back-to-back: with valid held high, next word SHALL be accepted in the IDLE cycle, giving exactly one idle cycle (txd=1) between frames.
REQ-020 Bit-time counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit counter SHALL count 0..DATA_W-1; no overflow beyond these ranges.
REQ-021 CLKS_PER_BIT=1 SHALL produce one cycle per bit with identical framing.
REQ-022 In IDLE txd SHALL be 1.

Reset
REQ-023 On any rising edge with clrn=0: txd=1, ready=0, busy=0, done=0, FSM=IDLE, counters=0, shift register=0.
REQ-024 First rising edge with clrn=1 SHALL set ready=1; valid is not accepted on that edge.
REQ-025 clrn=0 mid-frame SHALL abort the frame at that edge; no done pulse; txd=1 from next cycle.

Verification
REQ-026 DATA_W=8, CLKS_PER_BIT=4, din=0xA5 accepted -> txd: 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4; busy high 40 cycles; done high cycle 40 only.
REQ-027 valid held high with 0x00 then 0xFF -> two frames, exactly one idle cycle txd=1 between, ready low throughout each frame.
REQ-028 valid pulsed while busy=1, din=0x3C -> ignored; current frame unchanged; no extra frame.
REQ-029 din changed from 0x55 to 0xAA one cycle after acceptance -> line carries 0x55.
REQ-030 clrn low at cycle 15 of a frame -> next edge txd=1, busy=0, ready=0, done never pulses; ready=1 one edge after clrn high.
REQ-031 CLKS_PER_BIT=1, din=0x81 -> txd 0,1,0,0,0,0,0,0,1,1 over 10 cycles, done on cycle 10.
